// File: rtl/iot_pkg.sv
// Shared types and constants for the IOTDF engine and its result serializer.
// Holds block geometry, engine function codes and the serializer state encoding.
package iot_pkg;

    localparam int BYTES_PER_BLK = 16;
    localparam int BLK_W         = 128;
    localparam int IDX_W         = $clog2(BYTES_PER_BLK);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLK - 1);

    // Engine function codes, shared with the upstream controller.
    localparam logic [2:0] DES_ENCRYPT = 3'd1;
    localparam logic [2:0] DES_DECRYPT = 3'd2;
    localparam logic [2:0] CRC_GEN     = 3'd3;
    localparam logic [2:0] SORT        = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/iot_result_serializer_if.sv
// Result-in / byte-out signal bundle of the result serializer.
// The slave modport is the serializer's view; master is the surrounding system.
interface iot_result_serializer_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                       res_valid;
    logic [iot_pkg::BLK_W-1:0]  res_data;
    logic                       out_valid;
    logic [7:0]                 out_data;
    logic                       out_first;
    logic                       out_last;
    logic                       out_ready;
    logic                       almost_full;
    logic                       overflow;
    logic                       clr_overflow;
    logic [LVL_W-1:0]           level;

    modport master (
        output res_valid, res_data, out_ready, clr_overflow,
        input  out_valid, out_data, out_first, out_last, almost_full, overflow, level
    );

    modport slave (
        input  res_valid, res_data, out_ready, clr_overflow,
        output out_valid, out_data, out_first, out_last, almost_full, overflow, level
    );

endinterface

// File: rtl/iot_res_fifo.sv
// Synchronous result FIFO; a pop in the same cycle frees the slot for a push,
// so a write into a full FIFO is accepted when the head is being retired.
module iot_res_fifo
    import iot_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = BLK_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic                     push_ok_o,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_pop;

    assign do_pop    = pop_i && (count_q != '0);
    assign push_ok_o = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly PTR_W bits wide, so the increment wraps modulo DEPTH.
        if (push_ok_o) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)    rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok_o, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/iot_result_serializer.sv
// Buffers 128-bit engine results and streams each out as 16 bytes, LSB first,
// over a valid/ready byte link; reports fill level, almost_full and drops.
module iot_result_serializer
    import iot_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    iot_result_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ser_state_e       state_q, state_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             overflow_q, overflow_d;

    logic [BLK_W-1:0] head;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_last;
    logic             drop;

    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_first;
    logic             out_last;

    iot_res_fifo #(
        .DEPTH (DEPTH),
        .W     (BLK_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.res_valid),
        .push_data_i (bus.res_data),
        .pop_i       (pop_last),
        .push_ok_o   (push_ok),
        .head_o      (head),
        .count_o     (count)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        pop_last   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_first  = 1'b0;
        out_last   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    state_d    = SEND;
                    byte_idx_d = '0;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = head[{byte_idx_q, 3'b000} +: 8];
                out_first = (byte_idx_q == '0);
                out_last  = (byte_idx_q == LAST_IDX);
                if (bus.out_ready) begin
                    if (byte_idx_q == LAST_IDX) begin
                        pop_last   = 1'b1;
                        byte_idx_d = '0;
                        // Another stored result follows immediately with no idle bubble.
                        if (count <= CNT_W'(1)) state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop       = bus.res_valid && !push_ok;
    assign overflow_d = drop || (overflow_q && !bus.clr_overflow);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.out_first   = out_first;
    assign bus.out_last    = out_last;
    assign bus.overflow    = overflow_q;
    assign bus.almost_full = (count >= CNT_W'(AFULL_THRESH));
    assign bus.level       = count;

endmodule

// File: tb/tb_iot_result_serializer.sv
// Self-checking bench for iot_result_serializer: a queue-based reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_iot_result_serializer;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iot_result_serializer_if #(.DEPTH(DEPTH)) bus ();

    iot_result_serializer #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored results plus the position inside the packet on the link.
    logic [127:0] mq[$];
    bit           m_active;
    int           m_idx;
    bit           m_ovf;
    bit           cmp_en = 1'b0;

    function automatic void model_reset();
        mq.delete();
        m_active = 1'b0;
        m_idx    = 0;
        m_ovf    = 1'b0;
    endfunction

    function automatic void model_step();
        int n;
        bit pop;
        bit push;
        n    = mq.size();
        pop  = m_active && bus.out_ready && (m_idx == 15);
        push = bus.res_valid && ((n < DEPTH) || pop);
        if (!m_active) begin
            m_active = (n != 0);
            m_idx    = 0;
        end else if (bus.out_ready) begin
            if (m_idx == 15) begin
                m_active = (n > 1);
                m_idx    = 0;
            end else begin
                m_idx++;
            end
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(bus.res_data);
        if (bus.res_valid && !push) m_ovf = 1'b1;
        else if (bus.clr_overflow)  m_ovf = 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            logic [127:0] hw;
            logic [7:0]   eb;
            int           n;
            hw = m_active ? mq[0] : 128'h0;
            eb = m_active ? hw[8*m_idx +: 8] : 8'h00;
            n  = mq.size();
            check("m_valid", 32'(bus.out_valid),   32'(m_active));
            check("m_data",  32'(bus.out_data),    32'(eb));
            check("m_first", 32'(bus.out_first),   32'(m_active && m_idx == 0));
            check("m_last",  32'(bus.out_last),    32'(m_active && m_idx == 15));
            check("m_level", 32'(bus.level),       32'(n));
            check("m_afull", 32'(bus.almost_full), 32'(n >= AFULL));
            check("m_ovf",   32'(bus.overflow),    32'(m_ovf));
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives a one-cycle result strobe starting at the current negedge; returns one cycle later.
    task automatic pulse(input logic [127:0] d);
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid),   32'd0);
        check({tag, "_data"},  32'(bus.out_data),    32'd0);
        check({tag, "_first"}, 32'(bus.out_first),   32'd0);
        check({tag, "_last"},  32'(bus.out_last),    32'd0);
        check({tag, "_level"}, 32'(bus.level),       32'd0);
        check({tag, "_afull"}, 32'(bus.almost_full), 32'd0);
        check({tag, "_ovf"},   32'(bus.overflow),    32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] SEQ = 128'h0F0E0D0C0B0A09080706050403020100;

    initial begin
        logic [127:0] ra;
        logic [127:0] rb;
        logic [127:0] tmp;
        int           lvl;

        bus.res_valid    = 1'b0;
        bus.res_data     = '0;
        bus.out_ready    = 1'b0;
        bus.clr_overflow = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // Single result, consumer always ready.
        bus.out_ready = 1'b1;
        pulse(SEQ);
        check("single_t1_valid", 32'(bus.out_valid), 32'd0);
        check("single_t1_level", 32'(bus.level), 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("single_valid", 32'(bus.out_valid), 32'd1);
            check("single_data",  32'(bus.out_data),  32'(i));
            check("single_first", 32'(bus.out_first), 32'(i == 0));
            check("single_last",  32'(bus.out_last),  32'(i == 15));
        end
        @(negedge clk);
        check("single_end_valid", 32'(bus.out_valid), 32'd0);
        check("single_end_level", 32'(bus.level), 32'd0);

        // Stall: first byte held while the consumer is not ready.
        bus.out_ready = 1'b0;
        pulse(SEQ);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            check("stall_hold_data",  32'(bus.out_data),  32'h00);
            check("stall_hold_first", 32'(bus.out_first), 32'd1);
            check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            check("stall_data", 32'(bus.out_data), 32'(i));
            check("stall_last", 32'(bus.out_last), 32'(i == 15));
        end
        @(negedge clk);
        check("stall_end_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back: two results on consecutive cycles stream as 32 contiguous bytes.
        ra = rnd128();
        rb = rnd128();
        bus.res_valid = 1'b1;
        bus.res_data  = ra;
        @(negedge clk);
        bus.res_data  = rb;
        check("b2b_level1", 32'(bus.level), 32'd1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        check("b2b_level2", 32'(bus.level), 32'd2);
        check("b2b_byte0",  32'(bus.out_data), 32'(ra[7:0]));
        for (int j = 1; j < 32; j++) begin
            @(negedge clk);
            tmp = (j < 16) ? ra : rb;
            check("b2b_valid", 32'(bus.out_valid), 32'd1);
            check("b2b_data",  32'(bus.out_data),  32'(tmp[8*(j%16) +: 8]));
            check("b2b_first", 32'(bus.out_first), 32'(j == 16));
            if (j == 16) check("b2b_level_mid", 32'(bus.level), 32'd1);
        end
        @(negedge clk);
        check("b2b_end_level", 32'(bus.level), 32'd0);
        check("b2b_end_valid", 32'(bus.out_valid), 32'd0);

        // Overflow: five results into a four-entry FIFO with the link stalled.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = rnd128();
            @(negedge clk);
            lvl = (k + 1 > DEPTH) ? DEPTH : k + 1;
            check("ovf_level", 32'(bus.level),       32'(lvl));
            check("ovf_afull", 32'(bus.almost_full), 32'(lvl >= AFULL));
            check("ovf_flag",  32'(bus.overflow),    32'(k == 4));
        end
        bus.res_valid    = 1'b0;
        bus.clr_overflow = 1'b1;
        @(negedge clk);
        bus.clr_overflow = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        bus.out_ready = 1'b1;
        repeat (70) @(negedge clk);
        check("ovf_drained", 32'(bus.level), 32'd0);

        // Full FIFO plus a write coinciding with the final-byte handshake.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = rnd128();
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("fpp_full_level", 32'(bus.level), 32'd4);
        bus.out_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("fpp_at_last", 32'(bus.out_last), 32'd1);
        pulse(rnd128());
        check("fpp_level", 32'(bus.level),    32'd4);
        check("fpp_ovf",   32'(bus.overflow), 32'd0);
        repeat (80) @(negedge clk);
        check("fpp_drained", 32'(bus.level), 32'd0);

        // Reset in the middle of a packet.
        pulse(SEQ);
        repeat (8) @(negedge clk);
        check("rst_pre_byte7", 32'(bus.out_data), 32'h07);
        bus.res_valid = 1'b1;
        bus.res_data  = rnd128();
        @(posedge clk);
        #2 rst = 1'b1;
        bus.res_valid = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_after_valid", 32'(bus.out_valid), 32'd0);
        pulse(SEQ);
        @(negedge clk);
        check("rst_new_data",  32'(bus.out_data),  32'h00);
        check("rst_new_first", 32'(bus.out_first), 32'd1);
        repeat (20) @(negedge clk);

        // Randomized traffic, alternating light and heavy load.
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 400; c++) begin
                bus.res_valid    = ($urandom_range(0, (seg % 2) ? 5 : 20) == 0);
                bus.res_data     = rnd128();
                bus.out_ready    = (seg % 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                bus.clr_overflow = ($urandom_range(0, 40) == 0);
                @(negedge clk);
            end
        end
        bus.res_valid    = 1'b0;
        bus.clr_overflow = 1'b0;
        bus.out_ready    = 1'b1;
        repeat (100) @(negedge clk);
        check("rand_drained", 32'(bus.level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iot_result_serializer.md
Name: iot_result_serializer

Overview:
- Downstream stage of the IOTDF engine. Captures each 128-bit result delivered on a single-cycle valid pulse into a small FIFO.
- Streams each result out as 16 bytes, LSB byte first, over a valid/ready byte interface toward the IoT link transmitter.
- Has no backpressure path into the engine. Exposes almost_full for the upstream controller to throttle in_en, and a sticky overflow flag for dropped results.

Parameters:
- DEPTH, 4, FIFO entries of 128 bits; power of 2, >= 2.
- AFULL_THRESH, 3, almost_full asserts when stored entries >= this value; range 1..DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- res_valid  in  1  one-cycle result strobe from the engine (its valid)
- res_data  in  128  result word (engine iot_out), sampled when res_valid=1
- out_valid  out  1  byte available
- out_data  out  8  current byte
- out_first  out  1  current byte is byte 0 of a result
- out_last  out  1  current byte is byte 15 of a result
- out_ready  in  1  consumer accepts byte; handshake = out_valid & out_ready
- almost_full  out  1  count >= AFULL_THRESH
- overflow  out  1  sticky: a result was dropped
- clr_overflow  in  1  clears overflow
- level  out  clog2(DEPTH)+1  registered FIFO entry count

Behaviour:
- Reset: all outputs 0, count=0, rd/wr pointers=0, byte_idx=0, FSM=IDLE. Reset mid-packet discards the partial packet and all stored entries.
- FIFO write: res_valid=1 and (count<DEPTH or pop_last) -> store res_data at wr_ptr; wr_ptr wraps modulo DEPTH.
- pop_last = handshake while out_last=1. It frees the head entry in that same cycle, so a write into a full FIFO coinciding with pop_last is accepted.
- Drop: res_valid=1, count==DEPTH, no pop_last -> data discarded, overflow<=1.
- overflow clears on clr_overflow=1 unless a drop occurs in the same cycle; set wins.
- count update: +1 on write only, -1 on pop_last only, unchanged when both occur.
- FSM states: IDLE, SEND.
  - IDLE: out_valid=0. If count!=0 (registered), go to SEND with byte_idx=0.
  - SEND: out_valid=1; out_data = head[8*byte_idx+7 : 8*byte_idx]; out_first = (byte_idx==0); out_last = (byte_idx==15).
  - SEND on handshake with byte_idx<15: byte_idx+1.
  - SEND on handshake with byte_idx==15: rd_ptr+1, byte_idx=0. Stay in SEND if count>1 (back-to-back, no bubble); otherwise go to IDLE.
  - SEND without handshake: hold state, byte_idx and all out_* stable; out_valid never retracts.
- Latency: res_valid in cycle t into an empty FIFO with FSM in IDLE -> first out_valid in cycle t+2.
- Throughput: 1 byte/cycle with out_ready held high; a result occupies 16 cycles.
- almost_full and level derive from registered count only, so they update the cycle after the write or pop.
- Head entry storage is not modified while being serialized. A write never targets rd_ptr unless the FIFO is logically empty or pop_last is active.

Decomposition:
- Shared package iot_pkg:
  - BYTES_PER_BLK=16
  - BLK_W=128
  - function-code constants (DES_ENCRYPT=1, DES_DECRYPT=2, CRC_GEN=3, SORT=4)
  - serializer state enum {IDLE, SEND}
- Sub-module iot_res_fifo: parameterised sync FIFO.
  - Inputs: push, pop, push data.
  - Outputs: head word, count.
  - Implements the same-cycle pop-frees-slot rule.
- The serializer FSM, byte mux and overflow/almost_full logic stay in the top.

Test Plan:
- Single result: res_data=128'h0F0E0D0C0B0A09080706050403020100 pulsed at t, out_ready=1 -> out_data 00..0F in cycles t+2..t+17; out_first only with 00; out_last only with 0F; then out_valid=0.
- Stall: same result, out_ready=0 during t+2..t+5, then 1 -> out_data holds 00 with out_first=1 through t+5; sequence completes t+6..t+21 with no byte lost or duplicated.
- Back-to-back: two results pulsed 1 cycle apart, out_ready=1 -> 32 consecutive bytes, no idle cycle between byte 15 and next byte 0; level goes 1,2 then returns to 0 after second out_last.
- Overflow: out_ready=0, five pulses with DEPTH=4 -> level=4; almost_full=1 from level 3; overflow=1 after the fifth pulse; drained output shows results 1-4 only; clr_overflow=1 -> overflow=0.
- Full-plus-pop: FIFO full; res_valid coincides with the out_last handshake -> write accepted; level stays 4; overflow stays 0.
- Reset mid-packet: assert rst at byte 7 -> all outputs 0 immediately; after release a new pulse streams from byte 0 with out_first=1.
